// File: rtl/freq_meter.sv
// Gated rising-edge frequency meter with valid/ready result register.
// Optional FREQ_METER_DEGLITCH_EN adds a 3-sample majority filter.
module freq_meter #(
  parameter int GATE_CYCLES = 48000000,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sig_in,
  input  logic             count_ready,
  output logic [CNT_W-1:0] count,
  output logic             count_sat,
  output logic             overrun,
  output logic             count_valid
);

  localparam int GW = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GW-1:0] LP_LAST = GW'(GATE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_prev;
  logic             r_edge;
  logic [GW-1:0]    r_gate;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sat;
  logic [CNT_W-1:0] r_count;
  logic             r_csat;
  logic             r_ovr;
  logic             r_valid;

  logic             w_lvl;
  logic             w_term;
  logic             w_full;
  logic             w_xfer;
  logic [CNT_W-1:0] w_cnt_nx;
  logic             w_sat_nx;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= sig_in;
      r_sync2 <= r_sync1;
    end
  end

`ifdef FREQ_METER_DEGLITCH_EN
  logic r_h1;
  logic r_h2;
  logic r_maj;

  // 2-of-3 vote over consecutive synchronized samples
  always_ff @(posedge clk) begin
    if (reset) begin
      r_h1  <= 1'b0;
      r_h2  <= 1'b0;
      r_maj <= 1'b0;
    end else begin
      r_h1  <= r_sync2;
      r_h2  <= r_h1;
      r_maj <= (r_sync2 & r_h1) |
               (r_sync2 & r_h2) |
               (r_h1 & r_h2);
    end
  end

  assign w_lvl = r_maj;
`else
  assign w_lvl = r_sync2;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_prev <= 1'b0;
      r_edge <= 1'b0;
    end else begin
      r_prev <= w_lvl;
      r_edge <= w_lvl & ~r_prev;
    end
  end

  assign w_term   = (r_gate == LP_LAST);
  assign w_full   = &r_cnt;
  assign w_cnt_nx = (r_edge & ~w_full) ? r_cnt + CNT_W'(1) : r_cnt;
  assign w_sat_nx = r_sat | (r_edge & w_full);
  assign w_xfer   = r_valid & count_ready;

  // Counters free-run; output back-pressure never stalls them
  always_ff @(posedge clk) begin
    if (reset) begin
      r_gate <= '0;
      r_cnt  <= '0;
      r_sat  <= 1'b0;
    end else if (w_term) begin
      r_gate <= '0;
      r_cnt  <= '0;
      r_sat  <= 1'b0;
    end else begin
      r_gate <= r_gate + GW'(1);
      r_cnt  <= w_cnt_nx;
      r_sat  <= w_sat_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
      r_csat  <= 1'b0;
      r_ovr   <= 1'b0;
      r_valid <= 1'b0;
    end else if (w_term) begin
      r_count <= w_cnt_nx;
      r_csat  <= w_sat_nx;
      r_ovr   <= r_valid & ~count_ready;
      r_valid <= 1'b1;
    end else if (w_xfer) begin
      r_valid <= 1'b0;
    end
  end

  assign count       = r_count;
  assign count_sat   = r_csat;
  assign overrun     = r_ovr;
  assign count_valid = r_valid;

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter (GATE_CYCLES=100), main and CNT_W=4 instances.
// Build with +define+FREQ_METER_DEGLITCH_EN to check the filtered variant.
module tb_freq_meter;

`ifdef FREQ_METER_DEGLITCH_EN
  localparam int LAT = 5;
  localparam int GLITCH_CNT = 0;
`else
  localparam int LAT = 3;
  localparam int GLITCH_CNT = 14;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sig_in = 1'b0;
  logic       rdy = 1'b1;
  logic [31:0] cnt;
  logic       sat;
  logic       ovr;
  logic       vld;

  logic       sig2 = 1'b0;
  logic       rdy2 = 1'b1;
  logic [3:0] cnt2;
  logic       sat2;
  logic       ovr2;
  logic       vld2;

  int vec = 0;
  int errs = 0;
  int cyc = 0;
  int mode = 0;
  int rise_k = 0;
  int sat_mode = 0;

  always #5 clk = ~clk;

  freq_meter #(.GATE_CYCLES(100), .CNT_W(32)) u_dut (
    .clk(clk), .reset(reset), .sig_in(sig_in),
    .count_ready(rdy), .count(cnt), .count_sat(sat),
    .overrun(ovr), .count_valid(vld)
  );

  freq_meter #(.GATE_CYCLES(100), .CNT_W(4)) u_sat (
    .clk(clk), .reset(reset), .sig_in(sig2),
    .count_ready(rdy2), .count(cnt2), .count_sat(sat2),
    .overrun(ovr2), .count_valid(vld2)
  );

  // value driven during cycle k (sampled at the following posedge)
  function automatic logic sig_fn(input int k);
    case (mode)
      1: sig_fn = (k % 10) < 5;
      2: sig_fn = 1'b1;
      3: sig_fn = (k >= rise_k);
      4: sig_fn = (k % 7) == 3;
      default: sig_fn = 1'b0;
    endcase
  endfunction

  function automatic logic sig2_fn(input int k);
    if (sat_mode == 0) sig2_fn = 1'b0;
    else if (k < 95) sig2_fn = (k % 5) < 3;
    else sig2_fn = (k >= 110) && (k < 170) && ((k % 20) < 10);
  endfunction

  task automatic drive();
    sig_in = sig_fn(cyc);
    sig2 = sig2_fn(cyc);
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    drive();
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick();
  endtask

  task automatic release_rst();
    reset = 1'b0;
    cyc = 0;
    drive();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc = 0;
    drive();
    repeat (3) @(negedge clk);
    release_rst();
  endtask

  task automatic test_reset();
    mode = 1;
    reset = 1'b1;
    rdy = 1'b0;
    repeat (3) @(negedge clk);
    vec++;
    if ({vld, sat, ovr} !== 3'b000 || cnt !== 32'd0) begin
      errs++;
      $display("FAIL reset_main got v=%b s=%b o=%b c=%0d want 0", vld, sat, ovr, cnt);
    end
    vec++;
    if ({vld2, sat2, ovr2} !== 3'b000 || cnt2 !== 4'd0) begin
      errs++;
      $display("FAIL reset_sat got v=%b s=%b o=%b c=%0d want 0", vld2, sat2, ovr2, cnt2);
    end
  endtask

  task automatic test_periodic();
    mode = 1;
    rdy = 1'b1;
    do_reset();
    run_to(99);
    vec++;
    if (vld !== 1'b0) begin
      errs++;
      $display("FAIL per_early got vld=%b want 0", vld);
    end
    for (int w = 1; w <= 3; w++) begin
      run_to(100 * w);
      vec++;
      if (vld !== 1'b1 || cnt !== 32'd10 || ovr !== 1'b0 || sat !== 1'b0) begin
        errs++;
        $display("FAIL per_w%0d got v=%b c=%0d o=%b s=%b want 1/10/0/0", w, vld, cnt, ovr, sat);
      end
      tick();
      vec++;
      if (vld !== 1'b0) begin
        errs++;
        $display("FAIL per_pulse%0d got vld=%b want 0", w, vld);
      end
    end
  endtask

  task automatic test_backpressure();
    mode = 1;
    rdy = 1'b0;
    do_reset();
    run_to(150);
    vec++;
    if (vld !== 1'b1 || cnt !== 32'd10 || ovr !== 1'b0) begin
      errs++;
      $display("FAIL bp_first got v=%b c=%0d o=%b want 1/10/0", vld, cnt, ovr);
    end
    run_to(250);
    vec++;
    if (vld !== 1'b1 || cnt !== 32'd10 || ovr !== 1'b1) begin
      errs++;
      $display("FAIL bp_overrun got v=%b c=%0d o=%b want 1/10/1", vld, cnt, ovr);
    end
    rdy = 1'b1;
    run_to(251);
    vec++;
    if (vld !== 1'b0) begin
      errs++;
      $display("FAIL bp_accept got vld=%b want 0", vld);
    end
    rdy = 1'b0;
    run_to(300);
    vec++;
    if (vld !== 1'b1 || ovr !== 1'b0) begin
      errs++;
      $display("FAIL bp_empty_load got v=%b o=%b want 1/0", vld, ovr);
    end
    run_to(399);
    rdy = 1'b1;
    run_to(400);
    vec++;
    if (vld !== 1'b1 || cnt !== 32'd10 || ovr !== 1'b0) begin
      errs++;
      $display("FAIL bp_coincide got v=%b c=%0d o=%b want 1/10/0", vld, cnt, ovr);
    end
    run_to(401);
    vec++;
    if (vld !== 1'b0) begin
      errs++;
      $display("FAIL bp_after got vld=%b want 0", vld);
    end
  endtask

  task automatic test_const_high();
    mode = 2;
    rdy = 1'b1;
    do_reset();
    run_to(100);
    vec++;
    if (vld !== 1'b1 || cnt !== 32'd1) begin
      errs++;
      $display("FAIL const_first got v=%b c=%0d want 1/1", vld, cnt);
    end
    for (int w = 2; w <= 3; w++) begin
      run_to(100 * w);
      vec++;
      if (vld !== 1'b1 || cnt !== 32'd0) begin
        errs++;
        $display("FAIL const_w%0d got v=%b c=%0d want 1/0", w, vld, cnt);
      end
    end
  endtask

  task automatic test_saturate();
    mode = 0;
    sat_mode = 1;
    rdy2 = 1'b1;
    do_reset();
    run_to(100);
    vec++;
    if (vld2 !== 1'b1 || cnt2 !== 4'd15 || sat2 !== 1'b1) begin
      errs++;
      $display("FAIL sat_full got v=%b c=%0d s=%b want 1/15/1", vld2, cnt2, sat2);
    end
    run_to(200);
    vec++;
    if (vld2 !== 1'b1 || cnt2 !== 4'd3 || sat2 !== 1'b0) begin
      errs++;
      $display("FAIL sat_next got v=%b c=%0d s=%b want 1/3/0", vld2, cnt2, sat2);
    end
    sat_mode = 0;
  endtask

  task automatic test_terminal_edge();
    mode = 3;
    rdy = 1'b1;
    for (int d = 0; d <= 1; d++) begin
      rise_k = 99 - LAT + d;
      do_reset();
      run_to(100);
      vec++;
      if (cnt !== 32'(1 - d)) begin
        errs++;
        $display("FAIL term_w0_d%0d got c=%0d want %0d", d, cnt, 1 - d);
      end
      run_to(200);
      vec++;
      if (cnt !== 32'(d)) begin
        errs++;
        $display("FAIL term_w1_d%0d got c=%0d want %0d", d, cnt, d);
      end
    end
  endtask

  task automatic test_reset_mid();
    mode = 1;
    rdy = 1'b0;
    do_reset();
    run_to(150);
    vec++;
    if (vld !== 1'b1 || cnt !== 32'd10) begin
      errs++;
      $display("FAIL mid_pre got v=%b c=%0d want 1/10", vld, cnt);
    end
    reset = 1'b1;
    @(negedge clk);
    vec++;
    if (vld !== 1'b0 || cnt !== 32'd0 || ovr !== 1'b0) begin
      errs++;
      $display("FAIL mid_rst got v=%b c=%0d o=%b want 0/0/0", vld, cnt, ovr);
    end
    release_rst();
    run_to(99);
    vec++;
    if (vld !== 1'b0) begin
      errs++;
      $display("FAIL mid_early got vld=%b want 0", vld);
    end
    run_to(100);
    vec++;
    if (vld !== 1'b1 || cnt !== 32'd10) begin
      errs++;
      $display("FAIL mid_first got v=%b c=%0d want 1/10", vld, cnt);
    end
  endtask

  task automatic test_glitch();
    mode = 4;
    rdy = 1'b1;
    do_reset();
    for (int w = 1; w <= 3; w++) begin
      run_to(100 * w);
      vec++;
      if (vld !== 1'b1 || cnt !== 32'(GLITCH_CNT)) begin
        errs++;
        $display("FAIL glitch_w%0d got v=%b c=%0d want 1/%0d", w, vld, cnt, GLITCH_CNT);
      end
    end
  endtask

  initial begin
    test_reset();
    test_periodic();
    test_backpressure();
    test_const_high();
    test_saturate();
    test_terminal_edge();
    test_reset_mid();
    test_glitch();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
